// File: rtl/sdram_chip_model_if.sv
// SDR SDRAM pin bundle between the controller (master) and the chip model (slave).
// The controller drives command, address and write data; the chip returns read data.
interface sdram_chip_model_if;
    logic        sdram_cke;
    logic        sdram_ncs;
    logic        sdram_nras;
    logic        sdram_ncas;
    logic        sdram_nwe;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_dqm;
    logic [15:0] sdram_dq_i;
    logic [15:0] sdram_dq_o;
    logic        sdram_dq_oe;

    modport master (
        output sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
        output sdram_ba, sdram_a, sdram_dqm, sdram_dq_i,
        input  sdram_dq_o, sdram_dq_oe
    );

    modport slave (
        input  sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe,
        input  sdram_ba, sdram_a, sdram_dqm, sdram_dq_i,
        output sdram_dq_o, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_chip_model.sv
// Purpose: single-chip 16-bit 4-bank SDR SDRAM responder with protocol/timing violation flagging.
// Latency: read word k on dq_o after edge N+CL-1+k; write word 0 stored at the command edge.
// Backpressure: none; the chip accepts every command, a new READ/WRITE truncates any burst in flight.
module sdram_chip_model #(
    parameter int MEM_AW = 12,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RC   = 6
) (
    input  logic                clk,
    input  logic                init,
    sdram_chip_model_if.slave   sd,
    output logic                mode_valid,
    output logic [12:0]         mode_reg,
    output logic [15:0]         rfsh_cnt,
    output logic                err,
    output logic [2:0]          err_code
);
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_t;

    localparam logic [3:0] RCD = 4'(T_RCD);
    localparam logic [3:0] RP  = 4'(T_RP);
    localparam logic [3:0] RC  = 4'(T_RC);

    logic [15:0]       mem [2**MEM_AW];
    logic [3:0]        bank_open;
    logic [12:0]       bank_row [4];
    logic [3:0]        bank_cnt [4];
    logic [3:0]        rc_cnt;

    logic              rd_pend, rd_ap;
    logic [1:0]        rd_ba;
    logic [12:0]       rd_row;
    logic [8:0]        rd_col, rd_mask;
    logic [3:0]        rd_k, rd_last;
    logic [2:0]        rd_dly;
    logic              wr_pend, wr_ap;
    logic [1:0]        wr_ba;
    logic [12:0]       wr_row;
    logic [8:0]        wr_col, wr_mask;
    logic [3:0]        wr_k, wr_last;
    logic [15:0]       dq_o_q;
    logic              dq_oe_q;

    cmd_t              cmd;
    logic              is_rw;
    logic [1:0]        ba;
    logic [12:0]       a;
    logic [1:0]        bl_log;
    logic [8:0]        bl_mask;
    logic [3:0]        bl_last;
    logic [2:0]        cl_dly;
    logic [7:1]        viol;
    logic [2:0]        viol_code;
    logic              wr_en;
    logic [1:0]        wr_be;
    logic [MEM_AW-1:0] wr_addr;

    function automatic logic [MEM_AW-1:0] mem_addr(input logic [1:0] b, input logic [12:0] r,
                                                   input logic [8:0] c);
        logic [23:0] full;
        full = {b, r, c};
        return full[MEM_AW-1:0];
    endfunction

    // Sequential wrap inside the BL-aligned column block.
    function automatic logic [8:0] burst_col(input logic [8:0] c, input logic [3:0] k,
                                             input logic [8:0] m);
        return (c & ~m) | ((c + {5'd0, k}) & m);
    endfunction

    assign ba              = sd.sdram_ba;
    assign a               = sd.sdram_a;
    assign sd.sdram_dq_o   = dq_o_q;
    assign sd.sdram_dq_oe  = dq_oe_q;

    always_comb begin
        cmd     = (sd.sdram_cke && !sd.sdram_ncs) ? cmd_t'({sd.sdram_nras, sd.sdram_ncas, sd.sdram_nwe})
                                                  : CMD_NOP;
        is_rw   = (cmd == CMD_RD) || (cmd == CMD_WR);
        bl_log  = mode_reg[2] ? 2'd3 : mode_reg[1:0];
        bl_mask = (9'd1 << bl_log) - 9'd1;
        bl_last = {1'b0, bl_mask[2:0]};
        // CL-2 idle edges before the first word leaves the pipeline.
        cl_dly  = (mode_reg[6:4] > 3'd2) ? mode_reg[6:4] - 3'd2 : 3'd0;
    end

    always_comb begin
        viol[1] = (is_rw || cmd == CMD_ACT) && !mode_valid;
        viol[2] = (cmd == CMD_ACT) && bank_open[ba];
        viol[3] = is_rw && !bank_open[ba];
        viol[4] = is_rw && bank_open[ba] && (bank_cnt[ba] < RCD);
        viol[5] = ((cmd == CMD_REF) || (cmd == CMD_LMR)) && (|bank_open);
        viol[6] = (cmd == CMD_ACT) && !bank_open[ba] && (bank_cnt[ba] < RP);
        viol[7] = (cmd != CMD_NOP) && (rc_cnt < RC);
        viol_code = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (viol[i]) viol_code = 3'(i);
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_be   = 2'b00;
        wr_addr = '0;
        if (!init) begin
            if (cmd == CMD_WR) begin
                wr_en   = bank_open[ba];
                wr_be   = ~sd.sdram_dqm;
                wr_addr = mem_addr(ba, bank_row[ba], a[8:0]);
            end else if (cmd != CMD_RD && wr_pend) begin
                wr_en   = 1'b1;
                wr_be   = ~sd.sdram_dqm;
                wr_addr = mem_addr(wr_ba, wr_row, burst_col(wr_col, wr_k, wr_mask));
            end
        end
    end

    // Backing store survives init.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_be[0]) mem[wr_addr][7:0]  <= sd.sdram_dq_i[7:0];
            if (wr_be[1]) mem[wr_addr][15:8] <= sd.sdram_dq_i[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            bank_open  <= 4'b0000;
            for (int b = 0; b < 4; b++) bank_cnt[b] <= 4'hF;
            rc_cnt     <= 4'hF;
            mode_valid <= 1'b0;
            mode_reg   <= 13'd0;
            rfsh_cnt   <= 16'd0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            dq_o_q     <= 16'd0;
            dq_oe_q    <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bank_cnt[b] != 4'hF) bank_cnt[b] <= bank_cnt[b] + 4'd1;
            end
            if (rc_cnt != 4'hF) rc_cnt <= rc_cnt + 4'd1;
            dq_o_q  <= 16'd0;
            dq_oe_q <= 1'b0;

            if (rd_pend) begin
                if (rd_dly != 3'd0) begin
                    rd_dly <= rd_dly - 3'd1;
                end else begin
                    dq_o_q  <= mem[mem_addr(rd_ba, rd_row, burst_col(rd_col, rd_k, rd_mask))];
                    dq_oe_q <= 1'b1;
                    rd_k    <= rd_k + 4'd1;
                    if (rd_k == rd_last) begin
                        rd_pend <= 1'b0;
                        if (rd_ap) begin
                            bank_open[rd_ba] <= 1'b0;
                            bank_cnt[rd_ba]  <= 4'd1;
                        end
                    end
                end
            end

            if (wr_pend && !is_rw) begin
                wr_k <= wr_k + 4'd1;
                if (wr_k == wr_last) begin
                    wr_pend <= 1'b0;
                    if (wr_ap) begin
                        bank_open[wr_ba] <= 1'b0;
                        bank_cnt[wr_ba]  <= 4'd1;
                    end
                end
            end

            // A truncated burst still honours its auto-precharge.
            if (is_rw) begin
                if (rd_pend && rd_ap) begin
                    bank_open[rd_ba] <= 1'b0;
                    bank_cnt[rd_ba]  <= 4'd1;
                end
                if (wr_pend && wr_ap) begin
                    bank_open[wr_ba] <= 1'b0;
                    bank_cnt[wr_ba]  <= 4'd1;
                end
            end

            case (cmd)
                CMD_ACT: begin
                    bank_open[ba] <= 1'b1;
                    bank_row[ba]  <= a;
                    bank_cnt[ba]  <= 4'd1;
                end
                CMD_RD: begin
                    rd_pend <= bank_open[ba];
                    wr_pend <= 1'b0;
                    rd_dly  <= cl_dly;
                    rd_k    <= 4'd0;
                    rd_ba   <= ba;
                    rd_row  <= bank_row[ba];
                    rd_col  <= a[8:0];
                    rd_mask <= bl_mask;
                    rd_last <= bl_last;
                    rd_ap   <= a[10];
                end
                CMD_WR: begin
                    rd_pend <= 1'b0;
                    wr_pend <= bank_open[ba] && !mode_reg[9] && (bl_last != 4'd0);
                    wr_k    <= 4'd1;
                    wr_ba   <= ba;
                    wr_row  <= bank_row[ba];
                    wr_col  <= a[8:0];
                    wr_mask <= bl_mask;
                    wr_last <= bl_last;
                    wr_ap   <= a[10];
                    if (bank_open[ba] && a[10] && (mode_reg[9] || bl_last == 4'd0)) begin
                        bank_open[ba] <= 1'b0;
                        bank_cnt[ba]  <= 4'd1;
                    end
                end
                CMD_PRE: begin
                    for (int b = 0; b < 4; b++) begin
                        if (a[10] || ba == 2'(b)) begin
                            bank_open[b] <= 1'b0;
                            bank_cnt[b]  <= 4'd1;
                        end
                    end
                end
                CMD_REF: begin
                    if (rfsh_cnt != 16'hFFFF) rfsh_cnt <= rfsh_cnt + 16'd1;
                    rc_cnt <= 4'd1;
                end
                CMD_LMR: begin
                    mode_reg   <= a;
                    mode_valid <= 1'b1;
                end
                default: ;
            endcase

            if (viol_code != 3'd0) begin
                err <= 1'b1;
                if (!err) err_code <= viol_code;
            end
        end
    end
endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed bench for sdram_chip_model: startup, masked writes, wrapped CL2/BL4 reads,
// tRCD violation latching, and init during a read burst.
module tb_sdram_chip_model;
    localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        mode_valid;
    logic [12:0] mode_reg;
    logic [15:0] rfsh_cnt;
    logic        err;
    logic [2:0]  err_code;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_rd [4];

    always #5 clk = ~clk;

    sdram_chip_model_if sd ();

    sdram_chip_model #(.MEM_AW(12), .T_RCD(2), .T_RP(2), .T_RC(6)) dut (
        .clk        (clk),
        .init       (init),
        .sd         (sd),
        .mode_valid (mode_valid),
        .mode_reg   (mode_reg),
        .rfsh_cnt   (rfsh_cnt),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Drives one command for a single edge, returns at the following negedge with NOP on the bus.
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [1:0] m, input logic [15:0] d);
        sd.sdram_ncs = 1'b0;
        {sd.sdram_nras, sd.sdram_ncas, sd.sdram_nwe} = c;
        sd.sdram_ba   = b;
        sd.sdram_a    = addr;
        sd.sdram_dqm  = m;
        sd.sdram_dq_i = d;
        @(posedge clk);
        @(negedge clk);
        sd.sdram_ncs = 1'b1;
        {sd.sdram_nras, sd.sdram_ncas, sd.sdram_nwe} = C_NOP;
    endtask

    initial begin
        sd.sdram_cke  = 1'b1;
        sd.sdram_ncs  = 1'b1;
        {sd.sdram_nras, sd.sdram_ncas, sd.sdram_nwe} = C_NOP;
        sd.sdram_ba   = 2'd0;
        sd.sdram_a    = 13'd0;
        sd.sdram_dqm  = 2'b00;
        sd.sdram_dq_i = 16'd0;
        idle(2);
        check_val("rst_mode_valid", 32'(mode_valid), 32'd0);
        check_val("rst_mode_reg",   32'(mode_reg),   32'd0);
        check_val("rst_rfsh_cnt",   32'(rfsh_cnt),   32'd0);
        check_val("rst_dq_oe",      32'(sd.sdram_dq_oe), 32'd0);
        check_val("rst_err",        32'(err),        32'd0);
        check_val("rst_err_code",   32'(err_code),   32'd0);
        init = 1'b0;

        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        idle(7);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        idle(7);
        issue(C_LMR, 2'd0, 13'h222, 2'b00, 16'h0);
        check_val("start_mode_valid", 32'(mode_valid), 32'd1);
        check_val("start_mode_reg",   32'(mode_reg),   32'h222);
        check_val("start_rfsh_cnt",   32'(rfsh_cnt),   32'd2);
        check_val("start_err",        32'(err),        32'd0);

        issue(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0);
        idle(1);
        issue(C_WR, 2'd1, 13'd3, 2'b00, 16'hBEEF);
        check_val("wr_err", 32'(err), 32'd0);
        issue(C_RD, 2'd1, 13'd3, 2'b00, 16'h0);
        check_val("beef_lat_oe", 32'(sd.sdram_dq_oe), 32'd0);
        idle(1);
        check_val("beef_oe", 32'(sd.sdram_dq_oe), 32'd1);
        check_val("beef_dq", 32'(sd.sdram_dq_o), 32'hBEEF);
        idle(4);

        for (int c = 0; c < 4; c++) issue(C_WR, 2'd1, 13'(c), 2'b00, 16'(c));
        exp_rd[0] = 16'd2; exp_rd[1] = 16'd3; exp_rd[2] = 16'd0; exp_rd[3] = 16'd1;
        issue(C_RD, 2'd1, 13'd2, 2'b00, 16'h0);
        check_val("wrap_lat_oe", 32'(sd.sdram_dq_oe), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check_val($sformatf("wrap_oe%0d", k), 32'(sd.sdram_dq_oe), 32'd1);
            check_val($sformatf("wrap_dq%0d", k), 32'(sd.sdram_dq_o), 32'(exp_rd[k]));
        end
        idle(1);
        check_val("wrap_end_oe", 32'(sd.sdram_dq_oe), 32'd0);

        issue(C_WR, 2'd1, 13'd7, 2'b00, 16'hABCD);
        issue(C_WR, 2'd1, 13'd7, 2'b10, 16'h1234);
        issue(C_RD, 2'd1, 13'd7, 2'b00, 16'h0);
        idle(1);
        check_val("dqm_hi_mask", 32'(sd.sdram_dq_o), 32'hAB34);
        idle(4);
        issue(C_WR, 2'd1, 13'd7, 2'b11, 16'h5678);
        issue(C_RD, 2'd1, 13'd7, 2'b00, 16'h0);
        idle(1);
        check_val("dqm_all_mask", 32'(sd.sdram_dq_o), 32'hAB34);
        idle(4);
        check_val("pre_viol_err", 32'(err), 32'd0);

        issue(C_ACT, 2'd2, 13'd1, 2'b00, 16'h0);
        issue(C_RD, 2'd2, 13'd0, 2'b00, 16'h0);
        check_val("trcd_err",      32'(err),      32'd1);
        check_val("trcd_err_code", 32'(err_code), 32'd4);
        idle(5);
        issue(C_ACT, 2'd2, 13'd1, 2'b00, 16'h0);
        check_val("sticky_err",      32'(err),      32'd1);
        check_val("sticky_err_code", 32'(err_code), 32'd4);

        issue(C_RD, 2'd1, 13'd0, 2'b00, 16'h0);
        idle(2);
        check_val("burst_w1_oe", 32'(sd.sdram_dq_oe), 32'd1);
        check_val("burst_w1_dq", 32'(sd.sdram_dq_o), 32'd1);
        init = 1'b1;
        idle(1);
        init = 1'b0;
        check_val("init_dq_oe",      32'(sd.sdram_dq_oe), 32'd0);
        check_val("init_mode_valid", 32'(mode_valid),     32'd0);
        check_val("init_err",        32'(err),            32'd0);
        check_val("init_err_code",   32'(err_code),       32'd0);
        check_val("init_rfsh_cnt",   32'(rfsh_cnt),       32'd0);

        issue(C_LMR, 2'd0, 13'h222, 2'b00, 16'h0);
        issue(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0);
        idle(1);
        issue(C_RD, 2'd1, 13'd2, 2'b00, 16'h0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check_val($sformatf("kept_dq%0d", k), 32'(sd.sdram_dq_o), 32'(exp_rd[k]));
        end
        check_val("kept_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
